alu_seq_8bit: RTL



---
 rtl/alu_seq_8bit.sv | 225 ++++++++++++++++++++++
 1 files changed

// File: rtl/alu_seq_8bit.sv
// Sequential 8-bit ALU with start/busy/done handshake; one clock for most opcodes.
// Define ALU_MUL_EN to build the 8-clock shift-add multiplier for opcode 14 (MUL).
module alu_seq_8bit #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_start,
  input  logic [3:0]       in_op,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  input  logic             in_carry,
  output logic             out_busy,
  output logic             out_done,
  output logic [WIDTH-1:0] out_result,
  output logic             out_carry,
  output logic             out_zero
);

  localparam logic [3:0] OP_ADD   = 4'd0;
  localparam logic [3:0] OP_ADC   = 4'd1;
  localparam logic [3:0] OP_SUB   = 4'd2;
  localparam logic [3:0] OP_SBC   = 4'd3;
  localparam logic [3:0] OP_AND   = 4'd4;
  localparam logic [3:0] OP_OR    = 4'd5;
  localparam logic [3:0] OP_XOR   = 4'd6;
  localparam logic [3:0] OP_NOT   = 4'd7;
  localparam logic [3:0] OP_SHL   = 4'd8;
  localparam logic [3:0] OP_SHR   = 4'd9;
  localparam logic [3:0] OP_ROL   = 4'd10;
  localparam logic [3:0] OP_ROR   = 4'd11;
  localparam logic [3:0] OP_INC   = 4'd12;
  localparam logic [3:0] OP_DEC   = 4'd13;
  localparam logic [3:0] OP_MUL   = 4'd14;
  localparam logic [3:0] OP_PASSB = 4'd15;

  logic [8:0] ext_a_s;
  logic [8:0] ext_b_s;
  logic [8:0] ext_c_s;
  logic [8:0] wide_s;
  logic [7:0] alu_res_s;
  logic       alu_carry_s;

  logic [7:0] result_q, result_d;
  logic       carry_q, carry_d;
  logic       zero_q, zero_d;
  logic       done_q, done_d;

  assign ext_a_s = {1'b0, in_a};
  assign ext_b_s = {1'b0, in_b};
  assign ext_c_s = {8'h00, in_carry};

  // Single-cycle result; bit 8 of a 9-bit difference is the borrow.
  always_comb begin
    wide_s      = 9'h000;
    alu_res_s   = 8'h00;
    alu_carry_s = 1'b0;
    case (in_op)
      OP_ADD:   begin wide_s = ext_a_s + ext_b_s;           alu_res_s = wide_s[7:0]; alu_carry_s = wide_s[8]; end
      OP_ADC:   begin wide_s = ext_a_s + ext_b_s + ext_c_s; alu_res_s = wide_s[7:0]; alu_carry_s = wide_s[8]; end
      OP_SUB:   begin wide_s = ext_a_s - ext_b_s;           alu_res_s = wide_s[7:0]; alu_carry_s = wide_s[8]; end
      OP_SBC:   begin wide_s = ext_a_s - ext_b_s - ext_c_s; alu_res_s = wide_s[7:0]; alu_carry_s = wide_s[8]; end
      OP_AND:   alu_res_s = in_a & in_b;
      OP_OR:    alu_res_s = in_a | in_b;
      OP_XOR:   alu_res_s = in_a ^ in_b;
      OP_NOT:   alu_res_s = ~in_a;
      OP_SHL:   begin alu_res_s = {in_a[6:0], 1'b0};     alu_carry_s = in_a[7]; end
      OP_SHR:   begin alu_res_s = {1'b0, in_a[7:1]};     alu_carry_s = in_a[0]; end
      OP_ROL:   begin alu_res_s = {in_a[6:0], in_carry}; alu_carry_s = in_a[7]; end
      OP_ROR:   begin alu_res_s = {in_carry, in_a[7:1]}; alu_carry_s = in_a[0]; end
      OP_INC:   begin wide_s = ext_a_s + 9'h001;        alu_res_s = wide_s[7:0]; alu_carry_s = wide_s[8]; end
      OP_DEC:   begin wide_s = ext_a_s - 9'h001;        alu_res_s = wide_s[7:0]; alu_carry_s = wide_s[8]; end
      OP_MUL:   alu_res_s = 8'h00;
      OP_PASSB: alu_res_s = in_b;
      default:  alu_res_s = 8'h00;
    endcase
  end

`ifdef ALU_MUL_EN
  typedef enum logic [0:0] {ST_IDLE = 1'b0, ST_MUL = 1'b1} state_t;

  state_t      state_q, state_d;
  logic        busy_q, busy_d;
  logic [15:0] mcand_q, mcand_d;
  logic [7:0]  mplier_q, mplier_d;
  logic [15:0] acc_q, acc_d;
  logic [2:0]  cnt_q, cnt_d;
  logic [15:0] acc_sum_s;

  assign acc_sum_s = acc_q + (mplier_q[0] ? mcand_q : 16'h0000);

  // State and datapath registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      result_q <= 8'h00;
      carry_q  <= 1'b0;
      zero_q   <= 1'b0;
      mcand_q  <= 16'h0000;
      mplier_q <= 8'h00;
      acc_q    <= 16'h0000;
      cnt_q    <= 3'd0;
    end else begin
      state_q  <= state_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      result_q <= result_d;
      carry_q  <= carry_d;
      zero_q   <= zero_d;
      mcand_q  <= mcand_d;
      mplier_q <= mplier_d;
      acc_q    <= acc_d;
      cnt_q    <= cnt_d;
    end
  end

  // Next state: MUL runs exactly eight iterations.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: begin
        if (in_start && (in_op == OP_MUL)) state_d = ST_MUL;
        else                               state_d = ST_IDLE;
      end
      ST_MUL: begin
        if (cnt_q == 3'd7) state_d = ST_IDLE;
        else               state_d = ST_MUL;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Outputs and multiplier datapath; starts during MUL are dropped.
  always_comb begin
    result_d = result_q;
    carry_d  = carry_q;
    zero_d   = zero_q;
    done_d   = 1'b0;
    busy_d   = busy_q;
    mcand_d  = mcand_q;
    mplier_d = mplier_q;
    acc_d    = acc_q;
    cnt_d    = cnt_q;
    case (state_q)
      ST_IDLE: begin
        if (in_start && (in_op == OP_MUL)) begin
          mcand_d  = {8'h00, in_a};
          mplier_d = in_b;
          acc_d    = 16'h0000;
          cnt_d    = 3'd0;
          busy_d   = 1'b1;
        end else if (in_start) begin
          result_d = alu_res_s;
          carry_d  = alu_carry_s;
          zero_d   = (alu_res_s == 8'h00);
          done_d   = 1'b1;
        end else begin
          busy_d = 1'b0;
        end
      end
      ST_MUL: begin
        mcand_d  = {mcand_q[14:0], 1'b0};
        mplier_d = {1'b0, mplier_q[7:1]};
        acc_d    = acc_sum_s;
        cnt_d    = cnt_q + 3'd1;
        if (cnt_q == 3'd7) begin
          result_d = acc_sum_s[7:0];
          carry_d  = |acc_sum_s[15:8];
          zero_d   = (acc_sum_s[7:0] == 8'h00);
          done_d   = 1'b1;
          busy_d   = 1'b0;
        end else begin
          busy_d = 1'b1;
        end
      end
      default: begin
        busy_d = 1'b0;
      end
    endcase
  end

  assign out_busy = busy_q;
`else
  // Result and flag registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      done_q   <= 1'b0;
      result_q <= 8'h00;
      carry_q  <= 1'b0;
      zero_q   <= 1'b0;
    end else begin
      done_q   <= done_d;
      result_q <= result_d;
      carry_q  <= carry_d;
      zero_q   <= zero_d;
    end
  end

  // Every opcode, MUL included, completes in one clock.
  always_comb begin
    result_d = result_q;
    carry_d  = carry_q;
    zero_d   = zero_q;
    done_d   = 1'b0;
    if (in_start) begin
      result_d = alu_res_s;
      carry_d  = alu_carry_s;
      zero_d   = (alu_res_s == 8'h00);
      done_d   = 1'b1;
    end else begin
      done_d = 1'b0;
    end
  end

  assign out_busy = 1'b0;
`endif

  assign out_done   = done_q;
  assign out_result = result_q;
  assign out_carry  = carry_q;
  assign out_zero   = zero_q;

endmodule
